// File: rtl/iob_axi_arb_2to1.sv
// Two-master to one-slave AXI4 arbiter with independent write and read ownership.
// Define IOB_AXI_ARB_RR_EN for round-robin contests; otherwise port 0 has fixed priority.
module iob_axi_arb_2to1 #(
  parameter int AXI_ID_W   = 4,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  // master port 0
  input  logic [AXI_ID_W-1:0]     s0_axi_awid,
  input  logic [AXI_ADDR_W-1:0]   s0_axi_awaddr,
  input  logic [AXI_LEN_W-1:0]    s0_axi_awlen,
  input  logic [2:0]              s0_axi_awsize,
  input  logic [1:0]              s0_axi_awburst,
  input  logic                    s0_axi_awlock,
  input  logic [3:0]              s0_axi_awcache,
  input  logic [2:0]              s0_axi_awprot,
  input  logic [3:0]              s0_axi_awqos,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [AXI_DATA_W-1:0]   s0_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wlast,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [AXI_ID_W-1:0]     s0_axi_bid,
  output logic [1:0]              s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [AXI_ID_W-1:0]     s0_axi_arid,
  input  logic [AXI_ADDR_W-1:0]   s0_axi_araddr,
  input  logic [AXI_LEN_W-1:0]    s0_axi_arlen,
  input  logic [2:0]              s0_axi_arsize,
  input  logic [1:0]              s0_axi_arburst,
  input  logic                    s0_axi_arlock,
  input  logic [3:0]              s0_axi_arcache,
  input  logic [2:0]              s0_axi_arprot,
  input  logic [3:0]              s0_axi_arqos,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [AXI_ID_W-1:0]     s0_axi_rid,
  output logic [AXI_DATA_W-1:0]   s0_axi_rdata,
  output logic [1:0]              s0_axi_rresp,
  output logic                    s0_axi_rlast,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  // master port 1
  input  logic [AXI_ID_W-1:0]     s1_axi_awid,
  input  logic [AXI_ADDR_W-1:0]   s1_axi_awaddr,
  input  logic [AXI_LEN_W-1:0]    s1_axi_awlen,
  input  logic [2:0]              s1_axi_awsize,
  input  logic [1:0]              s1_axi_awburst,
  input  logic                    s1_axi_awlock,
  input  logic [3:0]              s1_axi_awcache,
  input  logic [2:0]              s1_axi_awprot,
  input  logic [3:0]              s1_axi_awqos,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [AXI_DATA_W-1:0]   s1_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wlast,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [AXI_ID_W-1:0]     s1_axi_bid,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [AXI_ID_W-1:0]     s1_axi_arid,
  input  logic [AXI_ADDR_W-1:0]   s1_axi_araddr,
  input  logic [AXI_LEN_W-1:0]    s1_axi_arlen,
  input  logic [2:0]              s1_axi_arsize,
  input  logic [1:0]              s1_axi_arburst,
  input  logic                    s1_axi_arlock,
  input  logic [3:0]              s1_axi_arcache,
  input  logic [2:0]              s1_axi_arprot,
  input  logic [3:0]              s1_axi_arqos,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [AXI_ID_W-1:0]     s1_axi_rid,
  output logic [AXI_DATA_W-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rlast,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  // shared memory port
  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]    m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_W-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [AXI_ID_W-1:0]     m_axi_arid,
  output logic [AXI_ADDR_W-1:0]   m_axi_araddr,
  output logic [AXI_LEN_W-1:0]    m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [AXI_ID_W-1:0]     m_axi_rid,
  input  logic [AXI_DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    wgrant_o,
  output logic                    rgrant_o
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;
  logic    wgrant, wgrant_nxt, rgrant, rgrant_nxt;
  logic    wwinner, rwinner;
  logic    own_awvalid, own_wvalid, own_wlast, own_bready;
  logic    own_arvalid, own_rready;

  assign wgrant_o = wgrant;
  assign rgrant_o = rgrant;

`ifdef IOB_AXI_ARB_RR_EN
  logic wlast_gnt, rlast_gnt;

  // a contested round goes to the port that did not win the previous grant
  assign wwinner = s1_axi_awvalid & (~s0_axi_awvalid | ~wlast_gnt);
  assign rwinner = s1_axi_arvalid & (~s0_axi_arvalid | ~rlast_gnt);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wlast_gnt <= 1'b1;
      rlast_gnt <= 1'b1;
    end else begin
      if (wstate == W_IDLE && (s0_axi_awvalid || s1_axi_awvalid)) wlast_gnt <= wwinner;
      if (rstate == R_IDLE && (s0_axi_arvalid || s1_axi_arvalid)) rlast_gnt <= rwinner;
    end
  end
`else
  assign wwinner = s1_axi_awvalid & ~s0_axi_awvalid;
  assign rwinner = s1_axi_arvalid & ~s0_axi_arvalid;
`endif

  // owner-side control selected by the registered grant
  assign own_awvalid = wgrant ? s1_axi_awvalid : s0_axi_awvalid;
  assign own_wvalid  = wgrant ? s1_axi_wvalid  : s0_axi_wvalid;
  assign own_wlast   = wgrant ? s1_axi_wlast   : s0_axi_wlast;
  assign own_bready  = wgrant ? s1_axi_bready  : s0_axi_bready;
  assign own_arvalid = rgrant ? s1_axi_arvalid : s0_axi_arvalid;
  assign own_rready  = rgrant ? s1_axi_rready  : s0_axi_rready;

  assign m_axi_awid    = wgrant ? s1_axi_awid    : s0_axi_awid;
  assign m_axi_awaddr  = wgrant ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m_axi_awlen   = wgrant ? s1_axi_awlen   : s0_axi_awlen;
  assign m_axi_awsize  = wgrant ? s1_axi_awsize  : s0_axi_awsize;
  assign m_axi_awburst = wgrant ? s1_axi_awburst : s0_axi_awburst;
  assign m_axi_awlock  = wgrant ? s1_axi_awlock  : s0_axi_awlock;
  assign m_axi_awcache = wgrant ? s1_axi_awcache : s0_axi_awcache;
  assign m_axi_awprot  = wgrant ? s1_axi_awprot  : s0_axi_awprot;
  assign m_axi_awqos   = wgrant ? s1_axi_awqos   : s0_axi_awqos;
  assign m_axi_wdata   = wgrant ? s1_axi_wdata   : s0_axi_wdata;
  assign m_axi_wstrb   = wgrant ? s1_axi_wstrb   : s0_axi_wstrb;
  assign m_axi_wlast   = own_wlast;

  assign m_axi_arid    = rgrant ? s1_axi_arid    : s0_axi_arid;
  assign m_axi_araddr  = rgrant ? s1_axi_araddr  : s0_axi_araddr;
  assign m_axi_arlen   = rgrant ? s1_axi_arlen   : s0_axi_arlen;
  assign m_axi_arsize  = rgrant ? s1_axi_arsize  : s0_axi_arsize;
  assign m_axi_arburst = rgrant ? s1_axi_arburst : s0_axi_arburst;
  assign m_axi_arlock  = rgrant ? s1_axi_arlock  : s0_axi_arlock;
  assign m_axi_arcache = rgrant ? s1_axi_arcache : s0_axi_arcache;
  assign m_axi_arprot  = rgrant ? s1_axi_arprot  : s0_axi_arprot;
  assign m_axi_arqos   = rgrant ? s1_axi_arqos   : s0_axi_arqos;

  // response payloads are broadcast; only the valids are steered
  assign s0_axi_bid   = m_axi_bid;
  assign s0_axi_bresp = m_axi_bresp;
  assign s1_axi_bid   = m_axi_bid;
  assign s1_axi_bresp = m_axi_bresp;
  assign s0_axi_rid   = m_axi_rid;
  assign s0_axi_rdata = m_axi_rdata;
  assign s0_axi_rresp = m_axi_rresp;
  assign s0_axi_rlast = m_axi_rlast;
  assign s1_axi_rid   = m_axi_rid;
  assign s1_axi_rdata = m_axi_rdata;
  assign s1_axi_rresp = m_axi_rresp;
  assign s1_axi_rlast = m_axi_rlast;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
      wgrant <= 1'b0;
      rgrant <= 1'b0;
    end else begin
      wstate <= wstate_nxt;
      rstate <= rstate_nxt;
      wgrant <= wgrant_nxt;
      rgrant <= rgrant_nxt;
    end
  end

  always_comb begin
    wstate_nxt     = wstate;
    wgrant_nxt     = wgrant;
    m_axi_awvalid  = 1'b0;
    m_axi_wvalid   = 1'b0;
    m_axi_bready   = 1'b0;
    s0_axi_awready = 1'b0;
    s1_axi_awready = 1'b0;
    s0_axi_wready  = 1'b0;
    s1_axi_wready  = 1'b0;
    s0_axi_bvalid  = 1'b0;
    s1_axi_bvalid  = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (s0_axi_awvalid || s1_axi_awvalid) begin
          wstate_nxt = W_ADDR;
          wgrant_nxt = wwinner;
        end
      end
      W_ADDR: begin
        m_axi_awvalid = own_awvalid;
        if (wgrant) s1_axi_awready = m_axi_awready;
        else        s0_axi_awready = m_axi_awready;
        if (own_awvalid && m_axi_awready) wstate_nxt = W_DATA;
      end
      W_DATA: begin
        m_axi_wvalid = own_wvalid;
        if (wgrant) s1_axi_wready = m_axi_wready;
        else        s0_axi_wready = m_axi_wready;
        if (own_wvalid && m_axi_wready && own_wlast) wstate_nxt = W_RESP;
      end
      W_RESP: begin
        m_axi_bready = own_bready;
        if (wgrant) s1_axi_bvalid = m_axi_bvalid;
        else        s0_axi_bvalid = m_axi_bvalid;
        if (m_axi_bvalid && own_bready) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_nxt     = rstate;
    rgrant_nxt     = rgrant;
    m_axi_arvalid  = 1'b0;
    m_axi_rready   = 1'b0;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    s0_axi_rvalid  = 1'b0;
    s1_axi_rvalid  = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (s0_axi_arvalid || s1_axi_arvalid) begin
          rstate_nxt = R_ADDR;
          rgrant_nxt = rwinner;
        end
      end
      R_ADDR: begin
        m_axi_arvalid = own_arvalid;
        if (rgrant) s1_axi_arready = m_axi_arready;
        else        s0_axi_arready = m_axi_arready;
        if (own_arvalid && m_axi_arready) rstate_nxt = R_DATA;
      end
      R_DATA: begin
        m_axi_rready = own_rready;
        if (rgrant) s1_axi_rvalid = m_axi_rvalid;
        else        s0_axi_rvalid = m_axi_rvalid;
        if (m_axi_rvalid && own_rready && m_axi_rlast) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_axi_arb_2to1.sv
// Directed bench for iob_axi_arb_2to1: vector table for the write path plus
// hand sequences for bursts, contested reads, concurrent traffic and mid-burst reset.
module tb_iob_axi_arb_2to1;

`ifdef IOB_AXI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam bit W = RR;  // winner of the first contested write round

  logic clk = 1'b0;
  logic arst_i;
  always #5 clk = ~clk;

  logic [3:0]  s0_axi_awid, s1_axi_awid, m_axi_awid;
  logic [23:0] s0_axi_awaddr, s1_axi_awaddr, m_axi_awaddr;
  logic [7:0]  s0_axi_awlen, s1_axi_awlen, m_axi_awlen;
  logic [2:0]  s0_axi_awsize, s1_axi_awsize, m_axi_awsize;
  logic [1:0]  s0_axi_awburst, s1_axi_awburst, m_axi_awburst;
  logic        s0_axi_awlock, s1_axi_awlock, m_axi_awlock;
  logic [3:0]  s0_axi_awcache, s1_axi_awcache, m_axi_awcache;
  logic [2:0]  s0_axi_awprot, s1_axi_awprot, m_axi_awprot;
  logic [3:0]  s0_axi_awqos, s1_axi_awqos, m_axi_awqos;
  logic        s0_axi_awvalid, s1_axi_awvalid, m_axi_awvalid;
  logic        s0_axi_awready, s1_axi_awready, m_axi_awready;
  logic [31:0] s0_axi_wdata, s1_axi_wdata, m_axi_wdata;
  logic [3:0]  s0_axi_wstrb, s1_axi_wstrb, m_axi_wstrb;
  logic        s0_axi_wlast, s1_axi_wlast, m_axi_wlast;
  logic        s0_axi_wvalid, s1_axi_wvalid, m_axi_wvalid;
  logic        s0_axi_wready, s1_axi_wready, m_axi_wready;
  logic [3:0]  s0_axi_bid, s1_axi_bid, m_axi_bid;
  logic [1:0]  s0_axi_bresp, s1_axi_bresp, m_axi_bresp;
  logic        s0_axi_bvalid, s1_axi_bvalid, m_axi_bvalid;
  logic        s0_axi_bready, s1_axi_bready, m_axi_bready;
  logic [3:0]  s0_axi_arid, s1_axi_arid, m_axi_arid;
  logic [23:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
  logic [7:0]  s0_axi_arlen, s1_axi_arlen, m_axi_arlen;
  logic [2:0]  s0_axi_arsize, s1_axi_arsize, m_axi_arsize;
  logic [1:0]  s0_axi_arburst, s1_axi_arburst, m_axi_arburst;
  logic        s0_axi_arlock, s1_axi_arlock, m_axi_arlock;
  logic [3:0]  s0_axi_arcache, s1_axi_arcache, m_axi_arcache;
  logic [2:0]  s0_axi_arprot, s1_axi_arprot, m_axi_arprot;
  logic [3:0]  s0_axi_arqos, s1_axi_arqos, m_axi_arqos;
  logic        s0_axi_arvalid, s1_axi_arvalid, m_axi_arvalid;
  logic        s0_axi_arready, s1_axi_arready, m_axi_arready;
  logic [3:0]  s0_axi_rid, s1_axi_rid, m_axi_rid;
  logic [31:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
  logic [1:0]  s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
  logic        s0_axi_rlast, s1_axi_rlast, m_axi_rlast;
  logic        s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
  logic        s0_axi_rready, s1_axi_rready, m_axi_rready;
  logic        wgrant_o, rgrant_o;

  iob_axi_arb_2to1 #(.AXI_ID_W(4), .AXI_ADDR_W(24), .AXI_DATA_W(32), .AXI_LEN_W(8)) dut (
    .clk_i(clk), .arst_i(arst_i),
    .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen),
    .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst), .s0_axi_awlock(s0_axi_awlock),
    .s0_axi_awcache(s0_axi_awcache), .s0_axi_awprot(s0_axi_awprot), .s0_axi_awqos(s0_axi_awqos),
    .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast),
    .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready),
    .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
    .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock),
    .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot), .s0_axi_arqos(s0_axi_arqos),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen),
    .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst), .s1_axi_awlock(s1_axi_awlock),
    .s1_axi_awcache(s1_axi_awcache), .s1_axi_awprot(s1_axi_awprot), .s1_axi_awqos(s1_axi_awqos),
    .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast),
    .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready),
    .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
    .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock),
    .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot), .s1_axi_arqos(s1_axi_arqos),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .wgrant_o(wgrant_o), .rgrant_o(rgrant_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {s0_axi_awid, s0_axi_awaddr, s0_axi_awlen, s0_axi_awsize, s0_axi_awburst, s0_axi_awlock,
     s0_axi_awcache, s0_axi_awprot, s0_axi_awqos, s0_axi_awvalid} = '0;
    {s1_axi_awid, s1_axi_awaddr, s1_axi_awlen, s1_axi_awsize, s1_axi_awburst, s1_axi_awlock,
     s1_axi_awcache, s1_axi_awprot, s1_axi_awqos, s1_axi_awvalid} = '0;
    {s0_axi_arid, s0_axi_araddr, s0_axi_arlen, s0_axi_arsize, s0_axi_arburst, s0_axi_arlock,
     s0_axi_arcache, s0_axi_arprot, s0_axi_arqos, s0_axi_arvalid} = '0;
    {s1_axi_arid, s1_axi_araddr, s1_axi_arlen, s1_axi_arsize, s1_axi_arburst, s1_axi_arlock,
     s1_axi_arcache, s1_axi_arprot, s1_axi_arqos, s1_axi_arvalid} = '0;
    {s0_axi_wdata, s0_axi_wstrb, s0_axi_wlast, s0_axi_wvalid, s0_axi_bready, s0_axi_rready} = '0;
    {s1_axi_wdata, s1_axi_wstrb, s1_axi_wlast, s1_axi_wvalid, s1_axi_bready, s1_axi_rready} = '0;
    {m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid, m_axi_arready} = '0;
    {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid} = '0;
  endtask

  task automatic wait_arvalid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      m_axi_rvalid = 1'b0;
      #3;
      if (m_axi_arvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // write-path vector: in = {aw0,aw1,w0,w1,wlast,m_awready,m_wready,m_bvalid,bready}
  // exp = {m_awvalid,m_wvalid,m_bready,wgrant,awready0,awready1,wready0,wready1,bvalid0,bvalid1}
  typedef struct {
    logic [8:0] in;
    logic [9:0] exp;
  } wvec_t;

  wvec_t wtab [20];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic wl, br;
    bit ok;
    int exp_g;
    int wph, wb, wsent, bcnt, mw, rph, rbeat, rsent, rrecv, rb;
    bit bpend, ract;

    wtab[0]  = '{9'b010001000, 10'b0000000000};
    wtab[1]  = '{9'b110001000, 10'b1001010000};
    wtab[2]  = '{9'b101110100, 10'b0101000100};
    wtab[3]  = '{9'b100000011, 10'b0011000001};
    wtab[4]  = '{9'b101000100, 10'b0001000000};
    wtab[5]  = '{9'b100000000, 10'b1000000000};
    wtab[6]  = '{9'b100001000, 10'b1000100000};
    wtab[7]  = '{9'b001000100, 10'b0100001000};
    wtab[8]  = '{9'b001010100, 10'b0100001000};
    wtab[9]  = '{9'b000000010, 10'b0000000010};
    wtab[10] = '{9'b000000011, 10'b0010000010};
    wtab[11] = '{9'b110000000, 10'b0000000000};
    wtab[12] = '{9'b110001000, {3'b100, W, ~W, W, 4'b0000}};
    wtab[13] = '{9'b001110100, {3'b010, W, 2'b00, ~W, W, 2'b00}};
    wtab[14] = '{9'b000000011, {3'b001, W, 4'b0000, ~W, W}};
    wtab[15] = '{9'b110000000, {3'b000, W, 6'b000000}};
    wtab[16] = '{9'b110001000, 10'b1000100000};
    wtab[17] = '{9'b001010100, 10'b0100001000};
    wtab[18] = '{9'b000000011, 10'b0010000010};
    wtab[19] = '{9'b000000000, 10'b0000000000};

    // reset with requests and m-side readiness present
    clear_inputs();
    arst_i = 1'b1;
    m_axi_awready = 1'b1; m_axi_arready = 1'b1; m_axi_wready = 1'b1;
    m_axi_bvalid = 1'b1; m_axi_rvalid = 1'b1;
    s0_axi_awvalid = 1'b1; s1_axi_arvalid = 1'b1; s0_axi_wvalid = 1'b1;
    s0_axi_bready = 1'b1; s1_axi_rready = 1'b1;
    step(); step(); #3;
    check("reset_handshakes",
          {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
           s0_axi_awready, s0_axi_wready, s0_axi_bvalid, s0_axi_arready, s0_axi_rvalid,
           s1_axi_awready, s1_axi_wready, s1_axi_bvalid, s1_axi_arready, s1_axi_rvalid}, 0);
    check("reset_wgrant", wgrant_o, 0);
    check("reset_rgrant", rgrant_o, 0);
    step();
    clear_inputs();
    arst_i = 1'b0;

    // write-path vectors, one per cycle
    for (int i = 0; i < 20; i++) begin
      step();
      {s0_axi_awvalid, s1_axi_awvalid, s0_axi_wvalid, s1_axi_wvalid, wl,
       m_axi_awready, m_axi_wready, m_axi_bvalid, br} = wtab[i].in;
      s0_axi_wlast = wl; s1_axi_wlast = wl;
      s0_axi_bready = br; s1_axi_bready = br;
      #3;
      check($sformatf("wvec[%0d]", i),
            {m_axi_awvalid, m_axi_wvalid, m_axi_bready, wgrant_o, s0_axi_awready, s1_axi_awready,
             s0_axi_wready, s1_axi_wready, s0_axi_bvalid, s1_axi_bvalid}, wtab[i].exp);
    end

    // s1 4-beat write, all fields forwarded
    step();
    clear_inputs();
    s1_axi_awid = 4'd5; s1_axi_awaddr = 24'h001230; s1_axi_awlen = 8'd3; s1_axi_awsize = 3'd2;
    s1_axi_awburst = 2'd1; s1_axi_awlock = 1'b1; s1_axi_awcache = 4'h3; s1_axi_awprot = 3'h2;
    s1_axi_awqos = 4'h7; s1_axi_awvalid = 1'b1;
    s0_axi_awid = 4'd9; s0_axi_awaddr = 24'hFFFFFF; s0_axi_awlen = 8'hAA; s0_axi_wstrb = 4'h1;
    s0_axi_wdata = 32'hDEAD_BEEF;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    #3;
    check("w1_idle_awvalid", m_axi_awvalid, 0);
    step(); #3;
    check("w1_awvalid", m_axi_awvalid, 1);
    check("w1_awid", m_axi_awid, 5);
    check("w1_awaddr", m_axi_awaddr, 24'h001230);
    check("w1_awlen", m_axi_awlen, 3);
    check("w1_awattr", {m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot,
                        m_axi_awqos}, {3'd2, 2'd1, 1'b1, 4'h3, 3'h2, 4'h7});
    check("w1_awready", {s0_axi_awready, s1_axi_awready}, 2'b01);
    check("w1_wgrant", wgrant_o, 1);
    for (int b = 0; b < 4; b++) begin
      step();
      s1_axi_awvalid = 1'b0;
      s1_axi_wvalid = 1'b1;
      s1_axi_wdata = 32'(32'h11 * (b + 1));
      s1_axi_wstrb = 4'hF;
      s1_axi_wlast = (b == 3);
      #3;
      check($sformatf("w1_wdata[%0d]", b), m_axi_wdata, 32'(32'h11 * (b + 1)));
      check($sformatf("w1_wctl[%0d]", b), {m_axi_wvalid, m_axi_wstrb, m_axi_wlast,
            s0_axi_wready, s1_axi_wready}, {1'b1, 4'hF, b == 3, 1'b0, 1'b1});
    end
    step();
    s1_axi_wvalid = 1'b0; s1_axi_wlast = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bid = 4'd5; m_axi_bresp = 2'd0;
    s0_axi_bready = 1'b1; s1_axi_bready = 1'b1;
    #3;
    check("w1_bvalid", {s0_axi_bvalid, s1_axi_bvalid, m_axi_bready}, 3'b011);
    check("w1_bid", s1_axi_bid, 5);
    check("w1_bresp", s1_axi_bresp, 0);

    // contested 2-beat reads from both ports
    step();
    clear_inputs();
    s0_axi_arid = 4'd1; s1_axi_arid = 4'd2; s0_axi_arlen = 8'd1; s1_axi_arlen = 8'd1;
    s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b1;
    s0_axi_rready = 1'b1; s1_axi_rready = 1'b1; m_axi_arready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_arvalid(ok);
      check($sformatf("rc_arvalid[%0d]", r), ok, 1);
      exp_g = RR ? (r % 2) : 0;
      check($sformatf("rc_grant[%0d]", r), rgrant_o, exp_g);
      check($sformatf("rc_arid[%0d]", r), m_axi_arid, (exp_g != 0) ? 2 : 1);
      for (int b = 0; b < 2; b++) begin
        step();
        m_axi_rvalid = 1'b1;
        m_axi_rdata = 32'(r * 16 + b);
        m_axi_rid = (exp_g != 0) ? 4'd2 : 4'd1;
        m_axi_rlast = (b == 1);
        #3;
        check($sformatf("rc_rvalid[%0d.%0d]", r, b), {s0_axi_rvalid, s1_axi_rvalid},
              (exp_g != 0) ? 2'b01 : 2'b10);
        check($sformatf("rc_rdata[%0d.%0d]", r, b), (exp_g != 0) ? s1_axi_rdata : s0_axi_rdata,
              32'(r * 16 + b));
      end
    end

    // s0 writes while s1 reads, random m-side and s1 rready back-pressure
    step();
    clear_inputs();
    {wph, wb, wsent, bcnt, mw, rph, rbeat, rsent, rrecv, rb} = '{default: 0};
    bpend = 1'b0; ract = 1'b0;
    for (int cyc = 0; cyc < 2000 && !(wph == 3 && rph == 2); cyc++) begin
      step();
      s0_axi_awvalid = (wph == 0); s0_axi_awlen = 8'd2; s0_axi_awid = 4'd1;
      s0_axi_wvalid = (wph == 1); s0_axi_wdata = 32'(32'hA000 + wsent);
      s0_axi_wlast = (wb == 2); s0_axi_bready = (wph == 2);
      m_axi_awready = 1'($urandom_range(0, 1)); m_axi_wready = 1'($urandom_range(0, 1));
      m_axi_bvalid = bpend;
      s1_axi_arvalid = (rph == 0); s1_axi_arlen = 8'd3;
      s1_axi_rready = 1'($urandom_range(0, 1));
      m_axi_arready = 1'($urandom_range(0, 1));
      m_axi_rvalid = ract; m_axi_rdata = 32'(32'hB000 + rsent); m_axi_rlast = (rbeat == 3);
      #3;
      if (m_axi_wvalid && m_axi_wready) begin
        check("cw_wdata", m_axi_wdata, 32'(32'hA000 + mw));
        mw++;
        if (m_axi_wlast) bpend = 1'b1;
      end
      if (m_axi_bvalid && m_axi_bready) bpend = 1'b0;
      if (s0_axi_awvalid && s0_axi_awready) wph = 1;
      if (s0_axi_wvalid && s0_axi_wready) begin
        wsent++;
        if (wb == 2) begin wb = 0; wph = 2; end
        else wb++;
      end
      if (s0_axi_bvalid && s0_axi_bready) begin
        bcnt++;
        wph = (bcnt == 3) ? 3 : 0;
      end
      if (s1_axi_arvalid && s1_axi_arready) rph = 1;
      if (m_axi_arvalid && m_axi_arready) begin ract = 1'b1; rbeat = 0; end
      if (m_axi_rvalid && m_axi_rready) begin
        rsent++;
        if (rbeat == 3) begin ract = 1'b0; rbeat = 0; end
        else rbeat++;
      end
      if (s1_axi_rvalid && s1_axi_rready) begin
        check("cr_rdata", s1_axi_rdata, 32'(32'hB000 + rrecv));
        rrecv++;
        if (s1_axi_rlast) begin
          rb++;
          rph = (rb == 3) ? 2 : 0;
        end
      end
    end
    check("cw_b_count", bcnt, 3);
    check("cw_beats", mw, 9);
    check("cr_bursts", rb, 3);
    check("cr_beats", rrecv, 12);

    // reset during beat 2 of an 8-beat read
    step();
    clear_inputs();
    s0_axi_arvalid = 1'b1; s0_axi_arlen = 8'd7; s0_axi_arid = 4'd4;
    m_axi_arready = 1'b1; s0_axi_rready = 1'b1;
    wait_arvalid(ok);
    check("mr_arvalid", ok, 1);
    for (int b = 0; b < 3; b++) begin
      step();
      s0_axi_arvalid = 1'b0;
      m_axi_rvalid = 1'b1; m_axi_rdata = 32'(b); m_axi_rlast = 1'b0; m_axi_rid = 4'd4;
      #3;
      check($sformatf("mr_beat[%0d]", b), s0_axi_rvalid, 1);
    end
    arst_i = 1'b1;
    #1;
    check("mr_in_reset", {s0_axi_rvalid, m_axi_rready}, 2'b00);
    step(); step();
    arst_i = 1'b0;
    #3;
    check("mr_after_rvalid", {s0_axi_rvalid, s1_axi_rvalid, m_axi_rready, m_axi_arvalid}, 4'b0000);
    check("mr_after_rgrant", rgrant_o, 0);
    step();
    m_axi_rvalid = 1'b0;
    s1_axi_arvalid = 1'b1; s1_axi_arid = 4'd3;
    #3;
    check("mr_idle_arvalid", m_axi_arvalid, 0);
    step(); #3;
    check("mr_new_arvalid", m_axi_arvalid, 1);
    check("mr_new_rgrant", rgrant_o, 1);
    check("mr_new_arid", m_axi_arid, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
